// File: rtl/interconn_pkg.sv
// Shared types and defaults for the MVU interconnect arbiter slice.
package interconn_pkg;

  localparam int N_DEF     = 8;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_ACTIVE = 1'b1} arb_state_t;

  typedef logic [N_DEF-1:0]     dst_mask_t;
  typedef logic [LEN_W_DEF-1:0] len_t;

endpackage

// File: rtl/interconn_arbiter_if.sv
// Request/ownership bundle between the MVU sources and the interconnect arbiter.
interface interconn_arbiter_if #(
  parameter int N     = interconn_pkg::N_DEF,
  parameter int LEN_W = interconn_pkg::LEN_W_DEF
);

  logic [N-1:0]            req;
  logic [N-1:0][N-1:0]     req_to;
  logic [N-1:0][LEN_W-1:0] req_len;
  logic [N-1:0]            beat;
  logic [N-1:0]            abort;
  logic [N-1:0]            gnt;
  logic [N-1:0]            xfer_en;
  logic [N-1:0][N-1:0]     dst_owner;
  logic [N-1:0]            dst_busy;
  logic [N-1:0]            viol;

  modport master (
    output req, req_to, req_len, beat, abort,
    input  gnt, xfer_en, dst_owner, dst_busy, viol
  );

  modport slave (
    input  req, req_to, req_len, beat, abort,
    output gnt, xfer_en, dst_owner, dst_busy, viol
  );

endinterface

// File: rtl/interconn_arb_src.sv
// Per-source burst tracker: IDLE/ACTIVE state, remaining-beat counter,
// owned destination mask and a beat-without-ownership flag.
module interconn_arb_src
  import interconn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             grant,
  input  logic [N-1:0]     req_to,
  input  logic [LEN_W-1:0] req_len,
  input  logic             beat,
  input  logic             abort,
  output logic             active,
  output logic [N-1:0]     own_mask,
  output logic             viol
);

  localparam logic S_IDLE   = ARB_IDLE;
  localparam logic S_ACTIVE = ARB_ACTIVE;

  logic             state;
  logic [LEN_W-1:0] rem;
  logic             last_beat;

  assign last_beat = beat && (rem == LEN_W'(1));
  assign active    = (state == S_ACTIVE);

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      rem      <= '0;
      own_mask <= '0;
      viol     <= 1'b0;
    end else begin
      viol <= beat && (state == S_IDLE);
      if (state == S_IDLE) begin
        if (grant) begin
          state    <= S_ACTIVE;
          rem      <= (req_len == '0) ? LEN_W'(1) : req_len;
          own_mask <= req_to;
        end
      end else begin
        // A beat coinciding with abort still counts; either way the burst ends.
        if (abort || last_beat) begin
          state    <= S_IDLE;
          own_mask <= '0;
        end else if (beat) begin
          rem <= rem - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/interconn_arbiter.sv
// Round-robin crossbar scheduler: grants each source exclusive use of its
// destination set, with head-of-line reservation to prevent starvation.
module interconn_arbiter
  import interconn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  interconn_arbiter_if.slave bus
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0]    ptr;
  logic [N-1:0]        active;
  logic [N-1:0]        viol;
  logic [N-1:0][N-1:0] own_mask;
  logic [N-1:0]        owned;
  logic [N-1:0]        grant;
  logic [N-1:0]        gnt_q;
  logic [N-1:0]        blocked;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    head_idx;
  logic                head_found;
  logic                head_gnt;
  logic                cand;
  logic                free;
  logic [N-1:0][N-1:0] owner;

  for (genvar g = 0; g < N; g++) begin : g_src
    interconn_arb_src #(.N(N), .LEN_W(LEN_W)) u_src (
      .clk      (clk),
      .clr_n    (clr_n),
      .grant    (grant[g]),
      .req_to   (bus.req_to[g]),
      .req_len  (bus.req_len[g]),
      .beat     (bus.beat[g]),
      .abort    (bus.abort[g]),
      .active   (active[g]),
      .own_mask (own_mask[g]),
      .viol     (viol[g])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    owned = '0;
    for (int i = 0; i < N; i++) begin
      if (active[i]) owned = owned | own_mask[i];
    end
  end

  // Scan from ptr; only registered ownership feeds the decision, so a
  // destination released at one edge becomes grantable at the next.
  always_comb begin
    blocked    = owned;
    grant      = '0;
    head_found = 1'b0;
    head_gnt   = 1'b0;
    head_idx   = '0;
    scan_idx   = '0;
    cand       = 1'b0;
    free       = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % N);
      cand     = bus.req[scan_idx] && !active[scan_idx] && (bus.req_to[scan_idx] != '0);
      free     = (bus.req_to[scan_idx] & blocked) == '0;
      if (cand) begin
        if (free) grant[scan_idx] = 1'b1;
        // A granted set is taken; a blocked head reserves its whole set.
        if (free || !head_found) blocked = blocked | bus.req_to[scan_idx];
        if (!head_found) begin
          head_found = 1'b1;
          head_idx   = scan_idx;
          head_gnt   = free;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      gnt_q <= grant;
      if (head_gnt) begin
        ptr <= (head_idx == PTR_W'(N - 1)) ? '0 : head_idx + PTR_W'(1);
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        owner[j][i] = own_mask[i][j] & active[i];
      end
    end
  end

  always_comb begin
    bus.dst_busy = '0;
    for (int j = 0; j < N; j++) begin
      bus.dst_busy[j] = |owner[j];
    end
  end

  assign bus.dst_owner = owner;
  assign bus.gnt       = gnt_q;
  assign bus.xfer_en   = active;
  assign bus.viol      = viol;

endmodule

// File: tb/tb_interconn_arbiter.sv
// Scenario bench for interconn_arbiter: grant expectations queued at request
// time and popped when gnt fires, plus per-cycle ownership/violation monitor.
module tb_interconn_arbiter;
  import interconn_pkg::*;

  localparam int N     = N_DEF;
  localparam int LEN_W = LEN_W_DEF;

  typedef logic [N-1:0][N-1:0] owner_t;
  typedef struct {
    logic [N-1:0] gnt;
    owner_t       owner;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  bit   mon_en = 1'b0;
  logic [N-1:0] pv   = '0;
  logic         pclr = 1'b0;

  interconn_arbiter_if #(.N(N), .LEN_W(LEN_W)) bus ();

  interconn_arbiter #(.N(N), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic owner_t owner_of(input int src, input dst_mask_t m);
    owner_t o;
    o = '0;
    for (int j = 0; j < N; j++) o[j][src] = m[j];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req     = '0;
    bus.req_to  = '0;
    bus.req_len = '0;
    bus.beat    = '0;
    bus.abort   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr_n = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  // Monitor: every destination has at most one owner; viol reflects the
  // previous cycle's beat without ownership.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ok;
      ok = 1'b1;
      for (int j = 0; j < N; j++) if (!$onehot0(bus.dst_owner[j])) ok = 1'b0;
      n_checks++; if (!ok) $display("FAIL dst_owner_onehot: got %h", bus.dst_owner); else n_pass++;
      n_checks++;
      if (bus.viol !== (pclr ? pv : '0)) $display("FAIL viol_monitor: got %h expected %h", bus.viol, (pclr ? pv : '0));
      else n_pass++;
    end
    pv   = bus.beat & ~bus.xfer_en;
    pclr = clr_n;
  end

  task automatic test_reset();
    bus.req = '1; bus.req_to = '1; bus.req_len = '1; bus.beat = '1; bus.abort = '0;
    clr_n = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.gnt !== '0) $display("FAIL reset gnt: got %h expected 0", bus.gnt); else n_pass++;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL reset xfer_en: got %h expected 0", bus.xfer_en); else n_pass++;
    n_checks++; if (bus.dst_owner !== '0) $display("FAIL reset dst_owner: got %h expected 0", bus.dst_owner); else n_pass++;
    n_checks++; if (bus.dst_busy !== '0) $display("FAIL reset dst_busy: got %h expected 0", bus.dst_busy); else n_pass++;
    n_checks++; if (bus.viol !== '0) $display("FAIL reset viol: got %h expected 0", bus.viol); else n_pass++;
    idle_inputs();
    clr_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    bus.req[0] = 1'b1; bus.req_to[0] = 8'h04; bus.req_len[0] = 8'd3;
    exp_q.push_back('{gnt: 8'h01, owner: owner_of(0, 8'h04), name: "basic"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    n_checks++; if (bus.dst_busy !== 8'h04) $display("FAIL basic dst_busy: got %h expected 04", bus.dst_busy); else n_pass++;
    bus.req[0] = 1'b0; bus.beat[0] = 1'b1;
    tick();
    n_checks++; if (bus.gnt !== '0) $display("FAIL basic gnt_pulse: got %h expected 0", bus.gnt); else n_pass++;
    tick();
    n_checks++; if (bus.xfer_en !== 8'h01) $display("FAIL basic xfer_after_2: got %h expected 01", bus.xfer_en); else n_pass++;
    tick();
    bus.beat[0] = 1'b0;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL basic xfer_after_3: got %h expected 0", bus.xfer_en); else n_pass++;
    n_checks++; if (bus.dst_busy !== '0) $display("FAIL basic busy_after_3: got %h expected 0", bus.dst_busy); else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    bus.req[1] = 1'b1; bus.req_to[1] = 8'h10; bus.req_len[1] = 8'd2;
    bus.req[3] = 1'b1; bus.req_to[3] = 8'h10; bus.req_len[3] = 8'd2;
    exp_q.push_back('{gnt: 8'h02, owner: owner_of(1, 8'h10), name: "conflict_first"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    n_checks++; if (dut.ptr !== 3'd2) $display("FAIL conflict ptr: got %0d expected 2", dut.ptr); else n_pass++;
    bus.req[1] = 1'b0; bus.beat[1] = 1'b1;
    exp_q.push_back('{gnt: 8'h08, owner: owner_of(3, 8'h10), name: "conflict_second"});
    tick();
    n_checks++; if (bus.gnt !== '0) $display("FAIL conflict hold1: got %h expected 0", bus.gnt); else n_pass++;
    tick();
    bus.beat[1] = 1'b0;
    n_checks++; if ((bus.gnt !== '0) || (bus.xfer_en !== '0)) $display("FAIL conflict release: got gnt %h xfer %h expected 0 0", bus.gnt, bus.xfer_en); else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    bus.req[3] = 1'b0; bus.beat[3] = 1'b1;
    tick();
    tick();
    bus.beat[3] = 1'b0;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL conflict done: got %h expected 0", bus.xfer_en); else n_pass++;
  endtask

  task automatic test_parallel();
    do_reset();
    bus.req[0] = 1'b1; bus.req_to[0] = 8'h01; bus.req_len[0] = 8'd1;
    bus.req[1] = 1'b1; bus.req_to[1] = 8'h02; bus.req_len[1] = 8'd1;
    bus.req[2] = 1'b1; bus.req_to[2] = 8'h0C; bus.req_len[2] = 8'd1;
    exp_q.push_back('{gnt: 8'h07, owner: owner_of(0, 8'h01) | owner_of(1, 8'h02) | owner_of(2, 8'h0C),
                      name: "parallel"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    bus.req = '0; bus.beat = 8'h07;
    tick();
    bus.beat = '0;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL parallel release: got %h expected 0", bus.xfer_en); else n_pass++;
  endtask

  task automatic test_starvation();
    do_reset();
    bus.req[5] = 1'b1; bus.req_to[5] = 8'h02; bus.req_len[5] = 8'd4;
    exp_q.push_back('{gnt: 8'h20, owner: owner_of(5, 8'h02), name: "starve_src5"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    bus.req[5] = 1'b0; bus.beat[5] = 1'b1;
    bus.req[0] = 1'b1; bus.req_to[0] = 8'hFF; bus.req_len[0] = 8'd1;
    bus.req[2] = 1'b1; bus.req_to[2] = 8'h08; bus.req_len[2] = 8'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus.gnt !== '0) $display("FAIL starve blocked_%0d gnt: got %h expected 0", c, bus.gnt); else n_pass++;
    end
    tick();
    bus.beat[5] = 1'b0;
    n_checks++; if ((bus.gnt !== '0) || (bus.xfer_en !== '0)) $display("FAIL starve src5_release: got gnt %h xfer %h expected 0 0", bus.gnt, bus.xfer_en); else n_pass++;
    exp_q.push_back('{gnt: 8'h01, owner: owner_of(0, 8'hFF), name: "starve_head"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    bus.req[0] = 1'b0; bus.beat[0] = 1'b1;
    exp_q.push_back('{gnt: 8'h04, owner: owner_of(2, 8'h08), name: "starve_src2"});
    tick();
    bus.beat[0] = 1'b0;
    n_checks++; if ((bus.gnt !== '0) || (bus.xfer_en !== '0)) $display("FAIL starve head_release: got gnt %h xfer %h expected 0 0", bus.gnt, bus.xfer_en); else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    bus.req[2] = 1'b0; bus.beat[2] = 1'b1;
    tick();
    bus.beat[2] = 1'b0;
  endtask

  task automatic test_edge_cases();
    logic [N-1:0] any;
    do_reset();
    bus.req[3] = 1'b1; bus.req_to[3] = 8'h10; bus.req_len[3] = 8'd0;
    exp_q.push_back('{gnt: 8'h08, owner: owner_of(3, 8'h10), name: "len0"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    bus.req[3] = 1'b0; bus.beat[3] = 1'b1;
    tick();
    bus.beat[3] = 1'b0;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL len0 one_beat: got %h expected 0", bus.xfer_en); else n_pass++;

    bus.req[4] = 1'b1; bus.req_to[4] = 8'h20; bus.req_len[4] = 8'd5;
    exp_q.push_back('{gnt: 8'h10, owner: owner_of(4, 8'h20), name: "abort"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    bus.req[4] = 1'b0; bus.beat[4] = 1'b1;
    tick();
    n_checks++; if (bus.xfer_en !== 8'h10) $display("FAIL abort still_active: got %h expected 10", bus.xfer_en); else n_pass++;
    bus.abort[4] = 1'b1;
    tick();
    bus.beat[4] = 1'b0; bus.abort[4] = 1'b0;
    n_checks++; if ((bus.xfer_en !== '0) || (bus.dst_busy !== '0)) $display("FAIL abort release: got xfer %h busy %h expected 0 0", bus.xfer_en, bus.dst_busy); else n_pass++;

    bus.beat[6] = 1'b1;
    tick();
    bus.beat[6] = 1'b0;
    n_checks++; if (bus.viol !== 8'h40) $display("FAIL viol pulse: got %h expected 40", bus.viol); else n_pass++;
    tick();
    n_checks++; if (bus.viol !== '0) $display("FAIL viol clear: got %h expected 0", bus.viol); else n_pass++;

    bus.req[7] = 1'b1; bus.req_to[7] = 8'h00; bus.req_len[7] = 8'd1;
    any = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      any = any | bus.gnt | bus.xfer_en;
    end
    bus.req[7] = 1'b0;
    n_checks++; if (any !== '0) $display("FAIL empty_mask grant: got %h expected 0", any); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req[i] = 1'b1; bus.req_to[i] = dst_mask_t'(1 << i); bus.req_len[i] = 8'd10;
    end
    tick();
    bus.req = '0;
    n_checks++; if (bus.xfer_en !== 8'h0F) $display("FAIL midrst active: got %h expected 0f", bus.xfer_en); else n_pass++;
    clr_n = 1'b0;
    tick();
    n_checks++; if (bus.gnt !== '0) $display("FAIL midrst gnt: got %h expected 0", bus.gnt); else n_pass++;
    n_checks++; if (bus.xfer_en !== '0) $display("FAIL midrst xfer_en: got %h expected 0", bus.xfer_en); else n_pass++;
    n_checks++; if (bus.dst_owner !== '0) $display("FAIL midrst dst_owner: got %h expected 0", bus.dst_owner); else n_pass++;
    n_checks++; if (bus.dst_busy !== '0) $display("FAIL midrst dst_busy: got %h expected 0", bus.dst_busy); else n_pass++;
    clr_n = 1'b1;
    bus.req[0] = 1'b1; bus.req_to[0] = 8'h80; bus.req_len[0] = 8'd1;
    bus.req[3] = 1'b1; bus.req_to[3] = 8'h80; bus.req_len[3] = 8'd1;
    exp_q.push_back('{gnt: 8'h01, owner: owner_of(0, 8'h80), name: "midrst_fresh"});
    tick();
    e = exp_q.pop_front();
    n_checks++; if (bus.gnt !== e.gnt) $display("FAIL %s gnt: got %h expected %h", e.name, bus.gnt, e.gnt); else n_pass++;
    n_checks++; if (bus.dst_owner !== e.owner) $display("FAIL %s dst_owner: got %h expected %h", e.name, bus.dst_owner, e.owner); else n_pass++;
    do_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_conflict();
    test_parallel();
    test_starvation();
    test_edge_cases();
    test_reset_mid_burst();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard leftover: got %0d expected 0", exp_q.size()); else n_pass++;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
